// File: rtl/sweep_pkg.sv
// Shared types and constants for the LED sweep controller.
package sweep_pkg;

  localparam int unsigned LED_W    = 8;
  localparam int unsigned RATE_W   = 8;
  localparam int unsigned BCNT_W   = 3;
  localparam int unsigned OP_W     = 2;
  localparam int unsigned BOUNCE_LEN = 7;

  localparam logic [OP_W-1:0] OP_LOAD  = 2'd0;
  localparam logic [OP_W-1:0] OP_MODE  = 2'd1;
  localparam logic [OP_W-1:0] OP_RATE  = 2'd2;
  localparam logic [OP_W-1:0] OP_BURST = 2'd3;

  typedef enum logic [1:0] {
    MODE_ROL    = 2'd0,
    MODE_ROR    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STOP  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [LED_W-1:0] data;
  } cmd_t;

  // Single-position rotate of the pattern; left moves bit 7 into bit 0.
  function automatic logic [LED_W-1:0] rot8(input logic [LED_W-1:0] v, input logic left);
    return left ? {v[LED_W-2:0], v[LED_W-1]} : {v[0], v[LED_W-1:1]};
  endfunction

endpackage

// File: rtl/sweep_tick_gen.sv
// Step prescaler: pulses o_tick_c once every (rate+1) << PRE_SHIFT enabled cycles.
module sweep_tick_gen
  import sweep_pkg::*;
#(
  parameter int unsigned PRE_SHIFT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic [RATE_W-1:0] i_rate,
  output logic              o_tick_c
);

  localparam int unsigned CNT_W = RATE_W + PRE_SHIFT;
  // ((rate+1) << PRE_SHIFT) - 1 == (rate << PRE_SHIFT) | low PRE_SHIFT ones
  localparam logic [CNT_W-1:0] LOW_ONES = CNT_W'((64'd1 << PRE_SHIFT) - 64'd1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_limit;

  assign w_limit  = (CNT_W'(i_rate) << PRE_SHIFT) | LOW_ONES;
  assign o_tick_c = i_en && (r_cnt == w_limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || !i_en || o_tick_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sweep_ctrl.sv
// LED sweep pattern controller with byte command interface.
// Optional build macro LED_PWM_EN adds a 4-bit brightness duty on the LED output.
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int unsigned      PRE_SHIFT       = 15,
  parameter logic [LED_W-1:0]  DEFAULT_PATTERN = 8'hFC,
  parameter logic [RATE_W-1:0] DEFAULT_RATE    = 8'd255,
  parameter mode_t            DEFAULT_MODE    = MODE_ROL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [LED_W-1:0]  cmd_data,
  output logic [LED_W-1:0]  led,
  output logic              step,
  output logic              busy
);

  cmd_t               w_cmd;
  logic               w_accept;
  logic               w_tick;
  logic               w_clr;

  state_t             r_state,     w_state_nxt;
  logic [LED_W-1:0]   r_pattern,   w_pattern_nxt;
  mode_t              r_mode,      w_mode_nxt;
  logic [RATE_W-1:0]  r_rate,      w_rate_nxt;
  dir_t               r_dir,       w_dir_nxt;
  logic [BCNT_W-1:0]  r_bcnt,      w_bcnt_nxt;
  logic [LED_W-1:0]   r_remaining, w_remaining_nxt;
  logic               r_step,      w_step_nxt;
  logic               r_busy,      w_busy_nxt;
  logic               r_cmd_ready, w_ready_nxt;

  assign w_cmd    = '{op: cmd_op, data: cmd_data};
  assign w_accept = cmd_valid && r_cmd_ready;

  sweep_tick_gen #(
    .PRE_SHIFT (PRE_SHIFT)
  ) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .i_en     (r_state != ST_STOP),
    .i_clr    (w_clr),
    .i_rate   (r_rate),
    .o_tick_c (w_tick)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: BURST 0 toggles RUN/STOP, BURST N enters burst, burst ends after its last step
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_accept && (w_cmd.op == OP_BURST)) begin
          w_state_nxt = (w_cmd.data != '0) ? ST_BURST : ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_accept && (w_cmd.op == OP_BURST)) begin
          w_state_nxt = (w_cmd.data != '0) ? ST_BURST : ST_RUN;
        end
      end
      ST_BURST: begin
        if (w_tick && (r_remaining == LED_W'(1))) begin
          w_state_nxt = ST_STOP;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Outputs follow the next state so they are registered alongside it
  always_comb begin
    w_busy_nxt  = 1'b0;
    w_ready_nxt = 1'b1;
    if (w_state_nxt == ST_BURST) begin
      w_busy_nxt  = 1'b1;
      w_ready_nxt = 1'b0;
    end
  end

`ifdef LED_PWM_EN
  logic [3:0]       r_duty, w_duty_nxt;
  logic [3:0]       r_pwm_cnt;
  logic [3:0]       w_pwm_nxt;
  logic [LED_W-1:0] r_led;
`endif

  // Datapath: an accepted command takes priority and swallows a coincident tick
  always_comb begin
    w_pattern_nxt   = r_pattern;
    w_mode_nxt      = r_mode;
    w_rate_nxt      = r_rate;
    w_dir_nxt       = r_dir;
    w_bcnt_nxt      = r_bcnt;
    w_remaining_nxt = r_remaining;
    w_step_nxt      = 1'b0;
    w_clr           = 1'b0;
`ifdef LED_PWM_EN
    w_duty_nxt      = r_duty;
`endif
    if (w_accept) begin
      case (w_cmd.op)
        OP_LOAD: begin
          w_pattern_nxt = w_cmd.data;
          w_clr         = 1'b1;
          w_bcnt_nxt    = '0;
          w_dir_nxt     = DIR_LEFT;
        end
        OP_MODE: begin
          w_mode_nxt = mode_t'(w_cmd.data[1:0]);
          w_bcnt_nxt = '0;
          w_dir_nxt  = DIR_LEFT;
`ifdef LED_PWM_EN
          w_duty_nxt = w_cmd.data[7:4];
`endif
        end
        OP_RATE: begin
          w_rate_nxt = w_cmd.data;
          w_clr      = 1'b1;
        end
        default: begin
          if (w_cmd.data != '0) begin
            w_remaining_nxt = w_cmd.data;
            w_clr           = 1'b1;
          end
        end
      endcase
    end else if (w_tick) begin
      if (r_state == ST_BURST) begin
        w_remaining_nxt = r_remaining - LED_W'(1);
      end
      case (r_mode)
        MODE_ROL: begin
          w_pattern_nxt = rot8(r_pattern, 1'b1);
          w_step_nxt    = 1'b1;
        end
        MODE_ROR: begin
          w_pattern_nxt = rot8(r_pattern, 1'b0);
          w_step_nxt    = 1'b1;
        end
        MODE_BOUNCE: begin
          w_pattern_nxt = rot8(r_pattern, r_dir == DIR_LEFT);
          w_step_nxt    = 1'b1;
          if (r_bcnt == BCNT_W'(BOUNCE_LEN - 1)) begin
            w_bcnt_nxt = '0;
            w_dir_nxt  = (r_dir == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
          end else begin
            w_bcnt_nxt = r_bcnt + BCNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pattern   <= DEFAULT_PATTERN;
      r_mode      <= DEFAULT_MODE;
      r_rate      <= DEFAULT_RATE;
      r_dir       <= DIR_LEFT;
      r_bcnt      <= '0;
      r_remaining <= '0;
      r_step      <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b1;
    end else begin
      r_pattern   <= w_pattern_nxt;
      r_mode      <= w_mode_nxt;
      r_rate      <= w_rate_nxt;
      r_dir       <= w_dir_nxt;
      r_bcnt      <= w_bcnt_nxt;
      r_remaining <= w_remaining_nxt;
      r_step      <= w_step_nxt;
      r_busy      <= w_busy_nxt;
      r_cmd_ready <= w_ready_nxt;
    end
  end

`ifdef LED_PWM_EN
  assign w_pwm_nxt = r_pwm_cnt + 4'd1;

  // Gate from next-cycle values so the dimmed LED still lines up with step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_duty    <= 4'hF;
      r_pwm_cnt <= 4'd0;
      r_led     <= DEFAULT_PATTERN;
    end else begin
      r_duty    <= w_duty_nxt;
      r_pwm_cnt <= w_pwm_nxt;
      r_led     <= w_pattern_nxt & {LED_W{w_pwm_nxt < w_duty_nxt}};
    end
  end

  assign led = r_led;
`else
  assign led = r_pattern;
`endif

  assign step      = r_step;
  assign busy      = r_busy;
  assign cmd_ready = r_cmd_ready;

endmodule
